// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared encodings for the shift-register sequencer and the register it drives.
package shift_seq_pkg;
    typedef enum logic [1:0] {
        CTRL_HOLD = 2'b00,
        CTRL_SHR  = 2'b01,
        CTRL_SHL  = 2'b10,
        CTRL_LOAD = 2'b11
    } ctrl_e;
    typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/shift_seq_timer.sv
// shift_seq_timer: per-bit hold counter and bit index for the serializer.
module shift_seq_timer #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output logic last_hold,
    output logic last_bit
);
    localparam int HW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(WIDTH);
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] bit_cnt;
    assign last_hold = hold_cnt == HW'(BIT_CYCLES - 1);
    assign last_bit  = bit_cnt == BW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
            bit_cnt  <= '0;
        end else if (advance) begin
            hold_cnt <= last_hold ? '0 : hold_cnt + 1'b1;
            bit_cnt  <= last_hold ? bit_cnt + 1'b1 : bit_cnt;
        end
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts parallel words and drives a universal shift register so it
// emits each word bit-serially, qualifying the live bit seen on the register output.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             fill_bit,
    output logic [1:0]       ctrl,
    output logic             serial_rs,
    output logic             serial_ls,
    output logic [WIDTH-1:0] parallel_out,
    input  logic [WIDTH-1:0] s_in,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             done
);
    state_e state, state_nx;
    ctrl_e  ctrl_c;
    logic   dir_q, fill_q, clear, advance, last_hold, last_bit;
    shift_seq_timer #(.WIDTH(WIDTH), .BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .advance   (advance),
        .last_hold (last_hold),
        .last_bit  (last_bit)
    );
    assign ctrl         = ctrl_c;
    assign serial_rs    = fill_q;
    assign serial_ls    = fill_q;
    assign parallel_out = in_data;
    assign ser_bit      = dir_q ? s_in[WIDTH-1] : s_in[0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (clear) begin
                dir_q  <= in_dir;
                fill_q <= fill_bit;
            end
        end
    end
    // clear doubles as the word-accept strobe: it fires exactly on a handshake
    always_comb begin
        state_nx  = state;
        ctrl_c    = CTRL_HOLD;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        advance   = 1'b0;
        if (state == IDLE) begin
            in_ready = 1'b1;
            if (in_valid) begin
                ctrl_c   = CTRL_LOAD;
                clear    = 1'b1;
                state_nx = SEND;
            end
        end else begin
            ser_valid = 1'b1;
            advance   = 1'b1;
            if (last_hold && !last_bit) begin
                ctrl_c = dir_q ? CTRL_SHL : CTRL_SHR;
            end else if (last_hold) begin
                done     = 1'b1;
                in_ready = 1'b1;
                ctrl_c   = in_valid ? CTRL_LOAD : CTRL_HOLD;
                clear    = in_valid;
                state_nx = in_valid ? SEND : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: two sequencers (BIT_CYCLES 1 and 3) each driving a 4-bit universal
// shift register; every cycle is compared with a word-level model of the serial stream.
module tb_shift_seq_ctrl;
    localparam int W = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_dir = 1'b0, fill_bit = 1'b0;
    logic [W-1:0] in_data = '0;
    logic rdy_a, rs_a, ls_a, sv_a, sb_a, dn_a, rdy_b, rs_b, ls_b, sv_b, sb_b, dn_b;
    logic [1:0] ctrl_a, ctrl_b;
    logic [W-1:0] po_a, po_b, reg_a, reg_b;
    logic o_rdy, o_rs, o_ls, o_sv, o_sb, o_done;
    logic [1:0] o_ctrl;
    logic [W-1:0] o_reg;
    bit sel = 1'b0;
    int checks = 0, errors = 0, nw = 0;
    logic [W-1:0] w_data [8];
    bit w_dir [8], w_fill [8];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(W), .BIT_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .in_dir(in_dir), .fill_bit(fill_bit), .ctrl(ctrl_a), .serial_rs(rs_a), .serial_ls(ls_a),
        .parallel_out(po_a), .s_in(reg_a), .ser_valid(sv_a), .ser_bit(sb_a), .done(dn_a)
    );
    shift_seq_ctrl #(.WIDTH(W), .BIT_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .in_dir(in_dir), .fill_bit(fill_bit), .ctrl(ctrl_b), .serial_rs(rs_b), .serial_ls(ls_b),
        .parallel_out(po_b), .s_in(reg_b), .ser_valid(sv_b), .ser_bit(sb_b), .done(dn_b)
    );

    // downstream universal shift register, shared reset
    function automatic logic [W-1:0] usr_next(logic [W-1:0] r, logic [1:0] c, logic rs, logic ls,
                                              logic [W-1:0] p);
        return c == 2'b01 ? {rs, r[W-1:1]} : c == 2'b10 ? {r[W-2:0], ls} : c == 2'b11 ? p : r;
    endfunction
    always_ff @(posedge clk or negedge rst_n)
        reg_a <= !rst_n ? '0 : usr_next(reg_a, ctrl_a, rs_a, ls_a, po_a);
    always_ff @(posedge clk or negedge rst_n)
        reg_b <= !rst_n ? '0 : usr_next(reg_b, ctrl_b, rs_b, ls_b, po_b);

    always_comb begin
        o_rdy  = sel ? rdy_b : rdy_a;
        o_rs   = sel ? rs_b : rs_a;
        o_ls   = sel ? ls_b : ls_a;
        o_sv   = sel ? sv_b : sv_a;
        o_sb   = sel ? sb_b : sb_a;
        o_done = sel ? dn_b : dn_a;
        o_ctrl = sel ? ctrl_b : ctrl_a;
        o_reg  = sel ? reg_b : reg_a;
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #2;
            ok = o_rdy && !o_sv;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle sel=%0d: in_ready=%b ser_valid=%b, required 1 0", sel, o_rdy, o_sv);
        end
    endtask

    // Drives words w_data[0..nw-1]; btb keeps in_valid high, noise scrambles ignored inputs.
    task automatic run_stream(input bit btb, input bit noise);
        int bc;
        bit last, nxt, eb;
        logic [1:0] ec;
        logic [W-1:0] er;
        bc = sel ? 3 : 1;
        for (int k = 0; k < nw; k++) begin
            if (k == 0 || !btb) begin
                @(posedge clk); #1;
                in_valid = 1'b1; in_data = w_data[k]; in_dir = w_dir[k]; fill_bit = w_fill[k];
                #1;
                checks++;
                if (o_rdy !== 1'b1 || o_ctrl !== 2'b11 || o_sv !== 1'b0 || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL handshake w%0d: rdy=%b ctrl=%b ser_valid=%b done=%b, required 1 11 0 0",
                             k, o_rdy, o_ctrl, o_sv, o_done);
                end
            end
            for (int c = 1; c <= W * bc; c++) begin
                last = c == W * bc;
                nxt  = btb && k + 1 < nw;
                @(posedge clk); #1;
                if (last) begin
                    in_valid = nxt;
                    in_data  = nxt ? w_data[k+1] : W'($urandom);
                    in_dir   = nxt ? w_dir[k+1] : in_dir;
                    fill_bit = nxt ? w_fill[k+1] : fill_bit;
                end else if (noise) begin
                    in_valid = btb | 1'($urandom_range(0, 1));
                    in_data  = W'($urandom);
                    in_dir   = 1'($urandom_range(0, 1));
                    fill_bit = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = btb;
                end
                #1;
                eb = w_dir[k] ? w_data[k][W-1-(c-1)/bc] : w_data[k][(c-1)/bc];
                ec = last ? (nxt ? 2'b11 : 2'b00) : (c % bc == 0 ? (w_dir[k] ? 2'b10 : 2'b01) : 2'b00);
                checks++;
                if (o_sv !== 1'b1 || o_sb !== eb) begin
                    errors++;
                    $display("FAIL ser_bit w%0d c%0d: valid=%b bit=%b, required 1 %b", k, c, o_sv, o_sb, eb);
                end
                checks++;
                if (o_ctrl !== ec) begin
                    errors++;
                    $display("FAIL ctrl w%0d c%0d: got %b, required %b", k, c, o_ctrl, ec);
                end
                checks++;
                if (o_rdy !== last || o_done !== last) begin
                    errors++;
                    $display("FAIL ready_done w%0d c%0d: rdy=%b done=%b, required %b %b",
                             k, c, o_rdy, o_done, last, last);
                end
                checks++;
                if (o_rs !== w_fill[k] || o_ls !== w_fill[k]) begin
                    errors++;
                    $display("FAIL fill w%0d c%0d: rs=%b ls=%b, required %b", k, c, o_rs, o_ls, w_fill[k]);
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        er = w_dir[nw-1] ? {w_data[nw-1][0], {(W-1){w_fill[nw-1]}}}
                         : {{(W-1){w_fill[nw-1]}}, w_data[nw-1][W-1]};
        checks++;
        if (o_rdy !== 1'b1 || o_sv !== 1'b0 || o_ctrl !== 2'b00 || o_done !== 1'b0 || o_reg !== er) begin
            errors++;
            $display("FAIL end_idle: rdy=%b valid=%b ctrl=%b done=%b reg=%b, required 1 0 00 0 %b",
                     o_rdy, o_sv, o_ctrl, o_done, o_reg, er);
        end
    endtask

    task automatic set_word(input int i, input logic [W-1:0] d, input bit dir, input bit fill);
        w_data[i] = d; w_dir[i] = dir; w_fill[i] = fill;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (rdy_a !== 1'b1 || ctrl_a !== 2'b00 || sv_a !== 1'b0 || dn_a !== 1'b0 ||
            rs_a !== 1'b0 || ls_a !== 1'b0 || reg_a !== '0 || rdy_b !== 1'b1 || sv_b !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b ctrl=%b valid=%b done=%b rs=%b ls=%b reg=%b, required 1 00 0 0 0 0 0000",
                     rdy_a, ctrl_a, sv_a, dn_a, rs_a, ls_a, reg_a);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_shift_right();
        sel = 0; wait_idle();
        set_word(0, 4'b1011, 1'b0, 1'b0); nw = 1;
        run_stream(1'b0, 1'b0);
    endtask

    task automatic test_shift_left();
        sel = 0; wait_idle();
        set_word(0, 4'b1011, 1'b1, 1'b1); nw = 1;
        run_stream(1'b0, 1'b0);
    endtask

    task automatic test_hold3();
        sel = 1; wait_idle();
        set_word(0, 4'b0110, 1'b0, 1'b0); nw = 1;
        run_stream(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 0; wait_idle();
        set_word(0, 4'hA, 1'b0, 1'b0); set_word(1, 4'h5, 1'b0, 1'b0); nw = 2;
        run_stream(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        sel = 0; wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 4'h6; in_dir = 1'b0; fill_bit = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_rdy !== 1'b1 || o_sv !== 1'b0 || o_done !== 1'b0 || o_ctrl !== 2'b00 || o_reg !== '0 ||
            o_rs !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b valid=%b done=%b ctrl=%b reg=%b rs=%b, required 1 0 0 00 0000 0",
                     o_rdy, o_sv, o_done, o_ctrl, o_reg, o_rs);
        end
        #1 rst_n = 1'b1;
        set_word(0, 4'h9, 1'b0, 1'b0); nw = 1;
        run_stream(1'b0, 1'b0);
    endtask

    task automatic test_noise();
        sel = 0; wait_idle();
        set_word(0, 4'hC, 1'b1, 1'b0); set_word(1, 4'h3, 1'b0, 1'b1); nw = 2;
        run_stream(1'b0, 1'b1);
        sel = 1; wait_idle();
        run_stream(1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            sel = r[0]; wait_idle();
            nw = $urandom_range(1, 8);
            for (int i = 0; i < nw; i++)
                set_word(i, W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_stream(1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_shift_right();
        test_shift_left();
        test_hold3();
        test_back_to_back();
        test_reset_mid_word();
        test_noise();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer that sits directly upstream of the team's 4-bit universal shift register and drives its `ctrl`, `serial_rs`, `serial_ls` and `parallel_in` inputs. It accepts parallel words over a valid/ready handshake, loads each word into the register, then issues timed shift commands so the register emits the word bit-serially. It monitors the register's `s_out` and presents the current serial bit with a qualifier.

## Interface
- `WIDTH`, default 4: word and shift-register width, ≥2.
- `BIT_CYCLES`, default 1: clock cycles each serial bit is held, ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  word offered.
- `in_ready`  out  1  word accepted when `in_valid && in_ready`.
- `in_data`  in  WIDTH  word to serialize.
- `in_dir`  in  1  0 = shift right (LSB first, bit from `s_in[0]`); 1 = shift left (MSB first, bit from `s_in[WIDTH-1]`). Sampled at handshake.
- `fill_bit`  in  1  value shifted into vacated positions. Sampled at handshake.
- `ctrl`  out  2  to register: 00 hold, 01 shift right, 10 shift left, 11 load.
- `serial_rs`  out  1  to register right-shift serial input; equals the latched fill.
- `serial_ls`  out  1  to register left-shift serial input; equals the latched fill.
- `parallel_out`  out  WIDTH  to register `parallel_in`; equals `in_data` (pass-through).
- `s_in`  in  WIDTH  from register `s_out`.
- `ser_valid`  out  1  `ser_bit` is a live data bit.
- `ser_bit`  out  1  current serial bit.
- `done`  out  1  one-cycle pulse on the last cycle of the last bit of a word.

## Operation
- Two states: IDLE and SEND. Internal registers:
  - `dir_q` and `fill_q`.
  - `bit_cnt`, width `$clog2(WIDTH)`, counting 0..WIDTH-1.
  - `hold_cnt`, width `max(1,$clog2(BIT_CYCLES))`, counting 0..BIT_CYCLES-1.
- IDLE:
  - `in_ready`=1, `ser_valid`=0.
  - On handshake: `ctrl`=11 (combinational, same cycle). Latch `dir_q`/`fill_q`, clear both counters, go to SEND.
  - No handshake: `ctrl`=00.
- SEND:
  - `ser_valid`=1.
  - `ser_bit` = `dir_q ? s_in[WIDTH-1] : s_in[0]`.
- Hold phase, `hold_cnt` < BIT_CYCLES-1: `ctrl`=00, `hold_cnt`++.
- Last hold cycle, bit not last: `ctrl`=01 (`dir_q`=0) or 10 (`dir_q`=1). `hold_cnt`←0, `bit_cnt`++.
- Last hold cycle of last bit (`bit_cnt`=WIDTH-1):
  - `done`=1 and `in_ready`=1.
  - If `in_valid`: `ctrl`=11, latch the new word, stay in SEND with counters cleared (back-to-back, no gap).
  - Else: `ctrl`=00, go to IDLE.
- `in_ready`=0 at all other SEND cycles. `in_valid`/`in_data` changes there are ignored.
- The register's shifted-in fill bits are never presented as data.

## Timing
- Handshake in cycle T. The register holds the word from T+1.
- Bit k (0-based) is valid during cycles T+1+k·BIT_CYCLES … T+(k+1)·BIT_CYCLES.
- `done` is asserted in cycle T+WIDTH·BIT_CYCLES.
- Throughput: one word per WIDTH·BIT_CYCLES cycles when `in_valid` is held high.
- `ctrl`, `in_ready`, `done`, `ser_valid` and `ser_bit` are combinational from state, counters, `in_valid` and `s_in`. No internal output register.
- Reset values:
  - State IDLE; counters, `dir_q` and `fill_q` = 0.
  - `in_ready`=1, `ctrl`=00 (while `in_valid`=0), `ser_valid`=0, `done`=0, `serial_rs`=`serial_ls`=0.
- Reset mid-word: immediate abort to IDLE, no `done`. The downstream register shares `rst_n` and clears to 0.
- BIT_CYCLES=1: every SEND cycle is a last-hold cycle.

## Structure
- Package `shift_seq_pkg` holds:
  - The `ctrl` enum: CTRL_HOLD=2'b00, CTRL_SHR=2'b01, CTRL_SHL=2'b10, CTRL_LOAD=2'b11. The shift register uses the same encoding.
  - The state enum: IDLE, SEND.
- One sub-module, `shift_seq_timer`:
  - Owns `hold_cnt`/`bit_cnt`, parameterized by WIDTH and BIT_CYCLES.
  - Inputs: clear and advance.
  - Outputs: `last_hold` and `last_bit`.

## Test plan
Bench instantiates this block plus the 4-bit shift register.
- WIDTH=4, BIT_CYCLES=1, `in_dir`=0, `in_data`=4'b1011:
  - `ser_bit` = 1,1,0,1 over cycles T+1..T+4.
  - `ctrl` = 11,01,01,01,00.
  - `done` only at T+4.
- Same word, `in_dir`=1, `fill_bit`=1: `ser_bit` = 1,0,1,1; the register reads 4'b1111 after the final shift.
- BIT_CYCLES=3, `in_data`=4'b0110, `in_dir`=0: each bit is held 3 cycles (0,1,1,0), `ctrl`=01 every third cycle, `done` at T+12.
- Back-to-back, `in_valid` held high with words 4'hA then 4'h5:
  - `in_ready` only at T and T+4.
  - `ser_valid` is continuous for 8 cycles.
  - Bits 0,1,0,1,1,0,1,0.
- Reset pulse at T+2 of a word:
  - IDLE, `ser_valid`=0, `in_ready`=1, and no `done`.
  - The next word 4'h9 then serializes correctly.
- `in_valid` toggled and `in_data` changed mid-word: output is unaffected and no extra handshake occurs.
